// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO registers for the MIPS execute stage.
// One radix-2 step per cycle: 32 CALC cycles, then a FIX cycle applies signs and writes HI/LO.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] opb_q, opb_d;
  logic [31:0] a_raw_q, a_raw_d;
  logic        div_q, div_d;
  logic        neg_res_q, neg_res_d;
  logic        neg_rem_q, neg_rem_d;
  logic        divz_q, divz_d;
  logic        done_q, done_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        is_signed;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_shift, div_diff;
  logic [63:0] div_next;
  logic [63:0] prod_neg;
  logic [31:0] quot_fix, rem_fix;

  assign is_signed = op[0];
  assign a_mag     = (is_signed && a[31]) ? (~a + 32'd1) : a;
  assign b_mag     = (is_signed && b[31]) ? (~b + 32'd1) : b;

  // Multiply: acc holds {partial product, remaining multiplier bits}, shifted right each step.
  assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
  assign mul_next = {mul_sum, acc_q[31:1]};

  // Divide: acc holds {remainder, dividend/quotient}, shifted left each step.
  assign div_shift = acc_q[63:31];
  assign div_diff  = div_shift - {1'b0, opb_q};
  assign div_next  = div_diff[32] ? {div_shift[31:0], acc_q[30:0], 1'b0}
                                  : {div_diff[31:0], acc_q[30:0], 1'b1};

  assign prod_neg = ~acc_q + 64'd1;
  assign quot_fix = neg_res_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
  assign rem_fix  = neg_rem_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    a_raw_d   = a_raw_q;
    div_d     = div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    divz_d    = divz_q;
    done_d    = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          div_d     = op[1];
          neg_res_d = is_signed & (a[31] ^ b[31]);
          neg_rem_d = is_signed & a[31];
          divz_d    = op[1] & (b == 32'd0);
          a_raw_d   = a;
          cnt_d     = 6'd0;
          if (op[1]) begin
            acc_d = {32'd0, a_mag};
            opb_d = b_mag;
          end else begin
            acc_d = {32'd0, b_mag};
            opb_d = a_mag;
          end
          state_d = StCalc;
        end else begin
          if (mthi) hi_d = wdata;
          if (mtlo) lo_d = wdata;
        end
      end
      StCalc: begin
        acc_d = div_q ? div_next : mul_next;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) state_d = StFix;
      end
      StFix: begin
        if (!div_q) begin
          hi_d = neg_res_q ? prod_neg[63:32] : acc_q[63:32];
          lo_d = neg_res_q ? prod_neg[31:0]  : acc_q[31:0];
        end else if (divz_q) begin
          hi_d = a_raw_q;
          lo_d = 32'hFFFF_FFFF;
        end else begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= 6'd0;
      acc_q     <= 64'd0;
      opb_q     <= 32'd0;
      a_raw_q   <= 32'd0;
      div_q     <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      divz_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      a_raw_q   <= a_raw_d;
      div_q     <= div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      divz_q    <= divz_d;
      done_q    <= done_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: expected HI/LO queued at start, compared on done.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic        mthi, mtlo;
  logic        busy, done;
  logic [31:0] hi, lo;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } result_t;

  result_t exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  muldiv_unit dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op and follow it to completion; optionally poke start/mthi mid-flight.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] ehi, input logic [31:0] elo,
                        input bit inject);
    result_t r;
    int      busy_cycles;
    bit      got;
    exp_q.push_back('{hi: ehi, lo: elo});
    @(negedge clk);
    start = 1'b1; op = o; a = av; b = bv;
    @(negedge clk);
    start = 1'b0;
    busy_cycles = 0;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      if (busy) busy_cycles++;
      if (inject && i == 5) begin
        start = 1'b1; mthi = 1'b1; wdata = 32'hAAAA_5555;
        op = 2'b00; a = 32'h1111_1111; b = 32'h2222_2222;
      end else begin
        start = 1'b0; mthi = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0; mthi = 1'b0;
    check_eq({tag, " done_seen"}, 64'(got), 64'd1);
    check_eq({tag, " busy_cycles"}, 64'(busy_cycles), 64'd33);
    check_eq({tag, " busy_at_done"}, 64'(busy), 64'd0);
    if (exp_q.size() == 0) begin
      check_eq({tag, " scoreboard_empty"}, 64'd1, 64'd0);
    end else begin
      r = exp_q.pop_front();
      check_eq({tag, " hi"}, 64'(hi), 64'(r.hi));
      check_eq({tag, " lo"}, 64'(lo), 64'(r.lo));
    end
    @(negedge clk);
    check_eq({tag, " done_width"}, 64'(done), 64'd0);
  endtask

  initial begin
    int done_cnt;
    rst = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    mthi = 1'b0; mtlo = 1'b0; wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    check_eq("reset hi", 64'(hi), 64'd0);
    check_eq("reset lo", 64'(lo), 64'd0);
    check_eq("reset busy", 64'(busy), 64'd0);
    check_eq("reset done", 64'(done), 64'd0);

    run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op("mult_neg", 2'b01, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    run_op("mult_pp", 2'b01, 32'd123456, 32'd789, 32'd0, 32'd97406784, 1'b0);
    run_op("divu", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    run_op("div_neg", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
    run_op("divu_z", 2'b10, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0);
    run_op("div_z", 2'b11, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b0);
    run_op("busy_ign", 2'b10, 32'd1000, 32'd33, 32'd10, 32'd30, 1'b1);

    // mtlo in idle, then both together
    @(negedge clk);
    mtlo = 1'b1; wdata = 32'h5;
    @(negedge clk);
    mtlo = 1'b0;
    check_eq("mtlo lo", 64'(lo), 64'd5);
    check_eq("mtlo hi_kept", 64'(hi), 64'd10);
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'hCAFE_F00D;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    check_eq("mthilo hi", 64'(hi), 64'hCAFE_F00D);
    check_eq("mthilo lo", 64'(lo), 64'hCAFE_F00D);

    // start and mthi together: start wins, HI untouched at that edge
    start = 1'b1; mthi = 1'b1; wdata = 32'h1357_9BDF; op = 2'b00; a = 32'd6; b = 32'd7;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0;
    check_eq("start_wins hi", 64'(hi), 64'hCAFE_F00D);
    check_eq("start_wins busy", 64'(busy), 64'd1);

    // reset around iteration 10 aborts without writing or pulsing done
    repeat (10) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check_eq("abort hi", 64'(hi), 64'd0);
    check_eq("abort lo", 64'(lo), 64'd0);
    check_eq("abort busy", 64'(busy), 64'd0);
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) done_cnt++;
      @(negedge clk);
    end
    check_eq("abort no_done", 64'(done_cnt), 64'd0);
    check_eq("abort hi_after", 64'(hi), 64'd0);

    run_op("post_abort", 2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
